vga_text_mem_ctrl: RTL and testbench

//  Owns the 16-bit VGA-side port of the 80x25 text memory (char+attr words, 2000 cells).

---
 rtl/vga_text_mem_ctrl_pkg.sv | 38 +++
 rtl/vga_text_cell_walker.sv | 43 ++++
 rtl/vga_text_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_vga_text_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_mem_ctrl_pkg.sv
// Shared geometry, command encodings and FSM states for the VGA text-memory port controller.
// Row-base arithmetic lives here so the top and the bench agree on one definition.
package vga_text_mem_ctrl_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int RW    = 5;

  localparam logic [AW-1:0] COLS_A      = AW'(COLS);
  localparam logic [AW-1:0] LAST_CELL_A = AW'(CELLS - 1);
  localparam logic [AW-1:0] TAIL_A      = AW'(CELLS - COLS);
  localparam logic [AW-1:0] LAST_DST_A  = AW'(CELLS - COLS - 1);
  localparam logic [RW-1:0] ROWS_R      = RW'(ROWS);

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'b00,
    OP_SCROLL   = 2'b01,
    OP_FILL_ROW = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_FILL,
    ST_DONE
  } state_e;

  // row*COLS with COLS=80 as two shifts, so no multiplier is implied.
  function automatic logic [AW-1:0] row_base(input logic [RW-1:0] row);
    return (AW'(row) << 6) + (AW'(row) << 4);
  endfunction

endpackage

// File: rtl/vga_text_cell_walker.sv
// Start/limit address walker with a registered last flag; used for fills and the scroll dst walk.
// Advances only when told to and never moves past the latched limit.
module vga_text_cell_walker
  import vga_text_mem_ctrl_pkg::*;
(
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          load,
  input  logic [AW-1:0] start_a,
  input  logic [AW-1:0] limit_a,
  input  logic          adv,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] limit_q;
  logic          last_q;
  logic [AW-1:0] addr_inc;

  assign addr_inc = addr_q + AW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q  <= '0;
      limit_q <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      addr_q  <= start_a;
      limit_q <= limit_a;
      last_q  <= (start_a == limit_a);
    end else if (adv && !last_q) begin
      addr_q  <= addr_inc;
      last_q  <= (addr_inc == limit_q);
    end
  end

  assign addr = addr_q;
  assign last = last_q;

endmodule

// File: rtl/vga_text_mem_ctrl.sv
// VGA-side port owner for the 80x25 text memory: display fetch has absolute priority,
// the clear/scroll/fill engine uses whatever cycles the fetcher leaves idle.
module vga_text_mem_ctrl
  import vga_text_mem_ctrl_pkg::*;
(
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_a,
  output logic          fetch_valid,
  output logic [DW-1:0] fetch_dr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [RW-1:0] cmd_row,
  input  logic [DW-1:0] cmd_fill,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_dw,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dr
);

  state_e        state_q, state_d;
  logic [DW-1:0] fill_q;
  logic [DW-1:0] hold_q;
  logic          rd_own_q, rd_own_d;
  logic          fetch_valid_q;

  logic          wk_load;
  logic [AW-1:0] wk_start;
  logic [AW-1:0] wk_limit;
  logic          wk_adv;
  logic [AW-1:0] wk_addr;
  logic          wk_last;
  logic [AW-1:0] row_start;

  assign row_start = row_base(cmd_row);

  vga_text_cell_walker u_walker (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (wk_load),
    .start_a   (wk_start),
    .limit_a   (wk_limit),
    .adv       (wk_adv),
    .addr      (wk_addr),
    .last      (wk_last)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      fill_q        <= '0;
      hold_q        <= '0;
      rd_own_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_own_q      <= rd_own_d;
      fetch_valid_q <= fetch_req;
      if (state_q == ST_IDLE && cmd_valid) fill_q <= cmd_fill;
      // Capture engine read data so a fetch that steals the write slot cannot lose it.
      if (rd_own_q) hold_q <= mem_dr;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    mem_a    = fetch_a;
    mem_dw   = fill_q;
    mem_we   = 1'b0;
    rd_own_d = 1'b0;
    wk_load  = 1'b0;
    wk_start = '0;
    wk_limit = '0;
    wk_adv   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OP_CLEAR: begin
              wk_load  = 1'b1;
              wk_start = '0;
              wk_limit = LAST_CELL_A;
              state_d  = ST_FILL;
            end
            OP_SCROLL: begin
              wk_load  = 1'b1;
              wk_start = '0;
              wk_limit = LAST_DST_A;
              state_d  = ST_SCR_RD;
            end
            OP_FILL_ROW: begin
              if (cmd_row < ROWS_R) begin
                wk_load  = 1'b1;
                wk_start = row_start;
                wk_limit = row_start + (COLS_A - AW'(1));
                state_d  = ST_FILL;
              end else begin
                state_d  = ST_DONE;
              end
            end
            OP_RSVD: state_d = ST_DONE;
          endcase
        end
      end

      ST_SCR_RD: begin
        if (!fetch_req) begin
          mem_a    = wk_addr + COLS_A;
          rd_own_d = 1'b1;
          state_d  = ST_SCR_WR;
        end
      end

      ST_SCR_WR: begin
        if (!fetch_req) begin
          mem_a  = wk_addr;
          mem_we = 1'b1;
          mem_dw = rd_own_q ? mem_dr : hold_q;
          if (wk_last) begin
            wk_load  = 1'b1;
            wk_start = TAIL_A;
            wk_limit = LAST_CELL_A;
            state_d  = ST_FILL;
          end else begin
            wk_adv  = 1'b1;
            state_d = ST_SCR_RD;
          end
        end
      end

      ST_FILL: begin
        if (!fetch_req) begin
          mem_a  = wk_addr;
          mem_we = 1'b1;
          mem_dw = fill_q;
          if (wk_last) state_d = ST_DONE;
          else         wk_adv  = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign fetch_valid = fetch_valid_q;
  assign fetch_dr    = fetch_valid_q ? mem_dr : '0;

endmodule

// File: tb/tb_vga_text_mem_ctrl.sv
// Self-checking bench: behavioural text memory, golden image model, and a fetch-data scoreboard.
module tb_vga_text_mem_ctrl;

  localparam int NCOLS  = 80;
  localparam int NROWS  = 25;
  localparam int NCELLS = 2000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        fetch_req;
  logic [10:0] fetch_a;
  logic        fetch_valid;
  logic [15:0] fetch_dr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_row;
  logic [15:0] cmd_fill;
  logic        busy;
  logic        done;
  logic [10:0] mem_a;
  logic [15:0] mem_dw;
  logic        mem_we;
  logic [15:0] mem_dr;

  logic [15:0] mem_model [NCELLS];
  logic [15:0] ref_img   [NCELLS];
  logic [15:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  int stall_cnt = 0;
  int we_viol = 0;
  int fmode = 0;
  logic eng_rd_prev = 1'b0;

  always #5 sys_clk = ~sys_clk;

  vga_text_mem_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .fetch_req   (fetch_req),
    .fetch_a     (fetch_a),
    .fetch_valid (fetch_valid),
    .fetch_dr    (fetch_dr),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_row     (cmd_row),
    .cmd_fill    (cmd_fill),
    .busy        (busy),
    .done        (done),
    .mem_a       (mem_a),
    .mem_dw      (mem_dw),
    .mem_we      (mem_we),
    .mem_dr      (mem_dr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Text memory with one-cycle read latency.
  always @(posedge sys_clk) begin
    if (mem_we && mem_a < 11'(NCELLS)) mem_model[mem_a] <= mem_dw;
    mem_dr <= (mem_a < 11'(NCELLS)) ? mem_model[mem_a] : 16'hDEAD;
  end

  // Per-edge monitor: scoreboard push, write/stall accounting.
  always @(posedge sys_clk) begin
    if (sys_rst_n) begin
      if (fetch_req) exp_q.push_back(mem_model[fetch_a]);
      if (fetch_req && mem_we) we_viol++;
      if (mem_we) wr_cnt++;
      if (fetch_req && busy) stall_cnt++;
    end
    eng_rd_prev <= sys_rst_n && busy && !fetch_req && !mem_we;
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n && fetch_valid) begin
      if (exp_q.size() == 0) check("fetch_unexpected", 32'd1, 32'd0);
      else                   check("fetch_dr", 32'(fetch_dr), 32'(exp_q.pop_front()));
    end
  end

  // Fetch driver: 0 off, 1 every third cycle, 2 right after each engine read.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      case (fmode)
        1:       fetch_req = (cyc % 3 == 0);
        2:       fetch_req = eng_rd_prev;
        default: fetch_req = 1'b0;
      endcase
      fetch_a = 11'($urandom_range(0, NCELLS - 1));
      cyc++;
    end
  end

  task automatic ref_clear(input logic [15:0] fill);
    for (int i = 0; i < NCELLS; i++) ref_img[i] = fill;
  endtask

  task automatic ref_scroll(input logic [15:0] fill);
    for (int i = 0; i < NCELLS - NCOLS; i++) ref_img[i] = ref_img[i + NCOLS];
    for (int i = NCELLS - NCOLS; i < NCELLS; i++) ref_img[i] = fill;
  endtask

  task automatic ref_fill_row(input int row, input logic [15:0] fill);
    if (row < NROWS)
      for (int i = 0; i < NCOLS; i++) ref_img[row * NCOLS + i] = fill;
  endtask

  task automatic check_img(input string tag);
    int nbad = 0;
    int first = -1;
    for (int i = 0; i < NCELLS; i++)
      if (mem_model[i] !== ref_img[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    if (nbad != 0) $display("first bad cell %0d: %0h vs %0h", first, mem_model[first], ref_img[first]);
    check(tag, 32'(nbad), 32'd0);
  endtask

  // Offers one command in the current cycle (cycle 0) and waits for done.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] row, input logic [15:0] fill,
                         output int lat, output int writes, output int stalls);
    int wb, sb;
    check("ready_before", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_row = row; cmd_fill = fill; cmd_valid = 1'b1;
    wb = wr_cnt; sb = stall_cnt;
    lat = 0;
    do begin
      @(posedge sys_clk);
      #1;
      lat++;
      if (lat == 1) begin
        cmd_valid = 1'b0;
        check("ready_low_after_accept", 32'(cmd_ready), 32'd0);
      end
    end while (!done && lat < 20000);
    if (!done) check("done_timeout", 32'd0, 32'd1);
    writes = wr_cnt - wb;
    stalls = stall_cnt - sb;
    @(posedge sys_clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  task automatic load_rows();
    int lat, wr, st;
    for (int r = 0; r < NROWS; r++) begin
      run_cmd(2'b10, 5'(r), 16'h0100 * 16'(r), lat, wr, st);
      ref_fill_row(r, 16'h0100 * 16'(r));
      check("row_load_lat", 32'(lat), 32'd81);
      check("row_load_writes", 32'(wr), 32'd80);
    end
  endtask

  initial begin
    int lat, wr, st, guard;
    logic [15:0] v;
    sys_rst_n = 1'b0;
    fetch_req = 1'b0; fetch_a = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_fill = '0;
    for (int i = 0; i < NCELLS; i++) begin
      v = 16'($urandom);
      mem_model[i] <= v;
      ref_img[i] = v;
    end
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_fetch_dr", 32'(fetch_dr), 32'd0);
    #20 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Clear with no fetch traffic.
    run_cmd(2'b00, 5'd0, 16'h0720, lat, wr, st);
    ref_clear(16'h0720);
    check("clear_lat", 32'(lat), 32'd2001);
    check("clear_writes", 32'(wr), 32'd2000);
    check_img("clear_img");

    // Scroll, no fetch.
    load_rows();
    run_cmd(2'b01, 5'd0, 16'h0720, lat, wr, st);
    ref_scroll(16'h0720);
    check("scroll_lat", 32'(lat), 32'd3921);
    check("scroll_writes", 32'(wr), 32'd2000);
    check_img("scroll_img");
    check("scroll_row0", 32'(mem_model[0]), 32'h0100);
    check("scroll_row24", 32'(mem_model[1999]), 32'h0720);

    // Scroll with a fetch every third cycle.
    load_rows();
    fmode = 1;
    run_cmd(2'b01, 5'd0, 16'h0A20, lat, wr, st);
    fmode = 0;
    ref_scroll(16'h0A20);
    check("scroll_f3_stalled", 32'(st > 0), 32'd1);
    check("scroll_f3_lat", 32'(lat), 32'(3921 + st));
    check_img("scroll_f3_img");

    // Scroll with a fetch wedged between every read and its write.
    load_rows();
    fmode = 2;
    run_cmd(2'b01, 5'd0, 16'h0B20, lat, wr, st);
    fmode = 0;
    ref_scroll(16'h0B20);
    check("scroll_hold_stalls", 32'(st), 32'd1920);
    check("scroll_hold_lat", 32'(lat), 32'(3921 + st));
    check_img("scroll_hold_img");

    // Fill last row, then out-of-range row and reserved op.
    run_cmd(2'b10, 5'd24, 16'h1F41, lat, wr, st);
    ref_fill_row(24, 16'h1F41);
    check("fill24_lat", 32'(lat), 32'd81);
    check("fill24_writes", 32'(wr), 32'd80);
    check_img("fill24_img");
    run_cmd(2'b10, 5'd31, 16'h5555, lat, wr, st);
    check("fill31_lat", 32'(lat), 32'd1);
    check("fill31_writes", 32'(wr), 32'd0);
    run_cmd(2'b11, 5'd0, 16'h6666, lat, wr, st);
    check("rsvd_lat", 32'(lat), 32'd1);
    check("rsvd_writes", 32'(wr), 32'd0);
    check_img("noop_img");

    // Reset in the middle of a clear.
    cmd_op = 2'b00; cmd_row = '0; cmd_fill = 16'h2222; cmd_valid = 1'b1;
    guard = 0;
    do begin
      @(posedge sys_clk); #1;
      cmd_valid = 1'b0;
      guard++;
    end while (!(mem_we && mem_a == 11'd1000) && guard < 5000);
    check("abort_reached_1000", 32'(mem_we && mem_a == 11'd1000), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_fetch_valid", 32'(fetch_valid), 32'd0);
    #12 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("abort_done_after", 32'(done), 32'd0);
    run_cmd(2'b00, 5'd0, 16'h1111, lat, wr, st);
    ref_clear(16'h1111);
    check("reclear_lat", 32'(lat), 32'd2001);
    check_img("reclear_img");

    repeat (3) @(posedge sys_clk);
    #1;
    check("we_in_fetch_cycle", 32'(we_viol), 32'd0);
    check("fetch_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
